serial_divider: RTL and testbench
=================================

// Module: serial_divider
// PURPOSE
// - Multi-cycle RV32M divide/remainder unit fed by the execute stage's div_in, answering on div_out.
// - Radix-2 restoring divider, one quotient bit per cycle; execute holds the instruction stalled until ready.
// - Handles DIV/DIVU/REM/REMU, including RISC-V divide-by-zero and signed-overflow results.
// PARAMETERS
// - XLEN      32   operand/result width; iteration count = XLEN
// PORTS
// - clock     in   1     rising-edge clock
// - reset     in   1     synchronous, active-low (reset==0 initialises all state)
// - enable    in   1     start pulse; high for exactly one cycle per divide
// - clear     in   1     abort in-flight operation (trap/mret flush)
// - op        in   4     one-hot: [0] DIV, [1] DIVU, [2] REM, [3] REMU
// - rdata1    in   XLEN  dividend
// - rdata2    in   XLEN  divisor
// - ready     out  1     result valid this cycle (one-cycle pulse)
// - result    out  XLEN  quotient or remainder per captured op
// BEHAVIOUR
// - FSM: IDLE -> BUSY -> DONE -> IDLE. Reset: state=IDLE, counter=0, ready=0, result=0, internal regs 0.
// - IDLE, enable=1 in cycle T: capture op, operand signs, |dividend|, |divisor| (signed ops only).
// -   divisor==0: go DONE; result = DIV/DIVU: all ones; REM/REMU: rdata1 unmodified.
// -   DIV/REM with rdata1=0x80000000, rdata2=0xFFFFFFFF: go DONE; DIV->0x80000000, REM->0.
// -   otherwise: counter=XLEN-1, remainder=0, quotient=|dividend|, go BUSY.
// - BUSY, each cycle: {rem,quo}<<=1; trial=rem-divisor (XLEN+1 bits); if trial>=0 rem=trial, quo[0]=1.
// -   counter decrements; after the XLEN-th iteration go DONE.
// - DONE: ready=1 one cycle; result = quotient or remainder; quotient negated if signed DIV and
// -   signs differ; remainder negated if signed REM and dividend negative. Then IDLE.
// - Latency: normal op ready in cycle T+XLEN+1 (T+33); special cases ready in T+1.
// - ready/result registered; result holds last value after ready drops; ready never high two cycles.
// - enable while BUSY/DONE: ignored (execute masks enable during stall; no queuing).
// - clear=1 in any state: next cycle IDLE, ready=0, result unchanged; clear beats simultaneous enable.
// - reset==0 mid-operation: abort exactly as reset from power-up; no ready pulse.
// - Unsigned ops: operands raw, no negation. op with zero or multiple bits set: treated as DIVU.
// CONFIGURATION
// - DIVIDER_CACHE_EN defined: keep last completed {op, rdata1, rdata2, result} plus valid bit;
// -   enable with identical op/operands and valid=1 -> DONE directly, ready in T+1 with cached result.
// -   Cache written only on normal DONE completion; special cases, clear and reset do not write;
// -   reset and clear invalidate it.
// - Not defined: no cache storage; every normal op takes XLEN+1 cycles.
// TESTING
// - DIVU 100/7 at T -> ready only in T+33, result 14; REMU same operands -> 2.
// - DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
// - DIV 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5 at T+1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
// - Start DIVU 100/7, clear at T+10 -> no ready ever; new DIVU 9/3 at T+12 -> 3 at T+45.
// - reset low at T+5 mid-divide -> ready=0, result=0; enable pulses during BUSY -> ignored, one ready.
// - DIVIDER_CACHE_EN: DIVU 100/7 twice -> second ready at T+1 with 14; after clear -> 33 cycles again.

Source files
------------

// File: rtl/serial_divider_if.sv
// Execute-stage <-> divider handshake bundle: operands and op in, pulsed result out.
// Latency: n/a (wires only).
// Backpressure: none; the execute stage stalls on its own until ready pulses.
interface serial_divider_if #(
  parameter int XLEN = 32
);
  logic            enable;
  logic            clear;
  logic [3:0]      op;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            ready;
  logic [XLEN-1:0] result;

  // execute stage drives the request and samples the answer
  modport master (
    output enable, clear, op, rdata1, rdata2,
    input  ready, result
  );

  // divider consumes the request and drives the answer
  modport slave (
    input  enable, clear, op, rdata1, rdata2,
    output ready, result
  );
endinterface

// File: rtl/serial_divider.sv
// RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient bit per cycle.
// Latency: XLEN+1 cycles from enable to ready; divide-by-zero, signed overflow and cache hits take 1.
// Backpressure: none; enable is ignored while busy, clear aborts. Optional result cache: DIVIDER_CACHE_EN.
module serial_divider #(
  parameter int XLEN = 32
) (
  input  logic           clock,
  input  logic           reset,
  serial_divider_if.slave div
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] result_q, result_d;

  // op decode; anything that is not exactly one known bit behaves as DIVU
  logic            op_div, op_rem, op_remu, op_signed, op_is_rem;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, sgn_ovf, start;

  // one restoring step
  logic [XLEN:0]   wide;
  logic            ge;
  logic [XLEN-1:0] diff, rem_it, quo_it, quo_fin, rem_fin;

  logic            cache_hit;
  logic [XLEN-1:0] cache_res;

  // decode the incoming request and its special cases
  always_comb begin
    op_div    = (div.op == 4'b0001);
    op_rem    = (div.op == 4'b0100);
    op_remu   = (div.op == 4'b1000);
    op_signed = op_div | op_rem;
    op_is_rem = op_rem | op_remu;
    sign_a    = op_signed & div.rdata1[XLEN-1];
    sign_b    = op_signed & div.rdata2[XLEN-1];
    abs_a     = sign_a ? (~div.rdata1 + 1'b1) : div.rdata1;
    abs_b     = sign_b ? (~div.rdata2 + 1'b1) : div.rdata2;
    div_zero  = (div.rdata2 == '0);
    sgn_ovf   = op_signed && (div.rdata1 == {1'b1, {(XLEN-1){1'b0}}}) && (div.rdata2 == '1);
    start     = (state_q == IDLE) && div.enable && !div.clear;
  end

  // one iteration: shift {rem,quo} left, subtract divisor if it fits.
  // The compare is XLEN+1 wide because the shifted remainder can exceed XLEN
  // bits when the divisor has its MSB set; the difference itself always fits.
  always_comb begin
    wide    = {rem_q, quo_q[XLEN-1]};
    ge      = (wide >= {1'b0, dvs_q});
    diff    = wide[XLEN-1:0] - dvs_q;
    rem_it  = ge ? diff : wide[XLEN-1:0];
    quo_it  = {quo_q[XLEN-2:0], ge};
    quo_fin = neg_quo_q ? (~quo_it + 1'b1) : quo_it;
    rem_fin = neg_rem_q ? (~rem_it + 1'b1) : rem_it;
  end

`ifdef DIVIDER_CACHE_EN
  logic            c_vld_q;
  logic [3:0]      c_op_q, op_cap_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_res_q, a_cap_q, b_cap_q;

  // hit only on an exact repeat of the last normally-completed request
  always_comb begin
    cache_hit = c_vld_q && (div.op == c_op_q) && (div.rdata1 == c_a_q) && (div.rdata2 == c_b_q);
    cache_res = c_res_q;
  end

  // capture raw request at start, fill on normal completion, drop on clear
  always_ff @(posedge clock) begin
    if (!reset) begin
      c_vld_q  <= 1'b0;
      c_op_q   <= '0;
      c_a_q    <= '0;
      c_b_q    <= '0;
      c_res_q  <= '0;
      op_cap_q <= '0;
      a_cap_q  <= '0;
      b_cap_q  <= '0;
    end else if (div.clear) begin
      c_vld_q <= 1'b0;
    end else begin
      if (start) begin
        op_cap_q <= div.op;
        a_cap_q  <= div.rdata1;
        b_cap_q  <= div.rdata2;
      end
      if (state_q == BUSY && cnt_q == '0) begin
        c_vld_q <= 1'b1;
        c_op_q  <= op_cap_q;
        c_a_q   <= a_cap_q;
        c_b_q   <= b_cap_q;
        c_res_q <= result_d;
      end
    end
  end
`else
  // without the cache every normal request iterates
  always_comb begin
    cache_hit = 1'b0;
    cache_res = '0;
  end
`endif

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; clear wins over everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (div_zero || sgn_ovf || cache_hit) state_d = DONE;
          else                                  state_d = BUSY;
        end
      end
      BUSY: begin
        if (div.clear)         state_d = IDLE;
        else if (cnt_q == '0)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath and registered outputs: operand setup, iteration, final sign fix
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_rem_d  = op_is_rem;
          neg_quo_d = op_div & (sign_a ^ sign_b);
          neg_rem_d = op_rem & sign_a;
          if (div_zero) begin
            ready_d  = 1'b1;
            result_d = op_is_rem ? div.rdata1 : '1;
          end else if (sgn_ovf) begin
            ready_d  = 1'b1;
            result_d = op_is_rem ? '0 : div.rdata1;
          end else if (cache_hit) begin
            ready_d  = 1'b1;
            result_d = cache_res;
          end else begin
            cnt_d = CW'(XLEN - 1);
            rem_d = '0;
            quo_d = abs_a;
            dvs_d = abs_b;
          end
        end
      end
      BUSY: begin
        if (!div.clear) begin
          rem_d = rem_it;
          quo_d = quo_it;
          if (cnt_q == '0) begin
            ready_d  = 1'b1;
            result_d = is_rem_q ? rem_fin : quo_fin;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign div.ready  = ready_q;
  assign div.result = result_q;

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider: expectations queued at issue, checked by a ready monitor.
// Latency: checks exact ready cycle (T+33 normal, T+1 special/cached).
// Backpressure: n/a; aborts (clear/reset) are checked by counting ready pulses.
module tb_serial_divider;

  localparam int XLEN = 32;
  localparam logic [3:0] DIV = 4'b0001, DIVU = 4'b0010, REM = 4'b0100, REMU = 4'b1000;

  logic clock = 1'b0;
  logic reset = 1'b0;

  serial_divider_if #(.XLEN(XLEN)) bus ();

  serial_divider #(.XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .div   (bus.slave)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int ready_seen = 0;
  logic prev_ready = 1'b0;
  logic [XLEN-1:0] exp_res_q[$];
  int unsigned     exp_due_q[$];

  // monitor: every ready pulse must match the oldest expectation, value and cycle
  always @(negedge clock) begin
    logic [XLEN-1:0] r;
    int unsigned d;
    if (bus.ready === 1'b1) begin
      ready_seen++;
      tests++;
      if (exp_res_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: cycle %0d result %h, none expected", cyc, bus.result);
      end else begin
        r = exp_res_q.pop_front();
        d = exp_due_q.pop_front();
        if (bus.result !== r || cyc != d) begin
          fails++;
          $display("FAIL sb_result: got %h at cycle %0d, expected %h at cycle %0d",
                   bus.result, cyc, r, d);
        end
      end
      if (prev_ready === 1'b1) begin
        fails++;
        $display("FAIL ready_pulse: ready high two cycles in a row at cycle %0d", cyc);
      end
    end
    prev_ready = bus.ready;
  end

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic goto_cycle(input int unsigned n);
    while (cyc < n) tick();
  endtask

  // drive enable for the current cycle; operands as given
  task automatic pulse(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.enable = 1'b1;
    bus.op     = op;
    bus.rdata1 = a;
    bus.rdata2 = b;
    tick();
    bus.enable = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int unsigned lat);
    exp_res_q.push_back(exp);
    exp_due_q.push_back(cyc + lat);
    pulse(op, a, b);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (exp_res_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_res_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d expected results still pending", exp_res_q.size());
      exp_res_q.delete();
      exp_due_q.delete();
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] exp, input int unsigned lat);
    issue(op, a, b, exp, lat);
    wait_done(60);
  endtask

  task automatic flush();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  int unsigned t0;
  int          seen0;

  initial begin
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.op     = '0;
    bus.rdata1 = '0;
    bus.rdata2 = '0;
    repeat (3) tick();
    reset = 1'b1;
    check("reset_ready", {31'b0, bus.ready}, 32'd0);
    check("reset_result", bus.result, 32'd0);

    // normal unsigned and signed divides
    run(DIVU, 32'd100, 32'd7, 32'd14, 33);
    check("result_hold", bus.result, 32'd14);
    check("ready_low_after", {31'b0, bus.ready}, 32'd0);
    run(REMU, 32'd100, 32'd7, 32'd2, 33);
    run(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run(REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run(DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 33);
    run(REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33);
    run(4'b0011, 32'd20, 32'd6, 32'd3, 33);

    // divide-by-zero and signed overflow answer next cycle
    run(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run(REMU, 32'd5, 32'd0, 32'd5, 1);
    run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // clear mid-divide: no ready, then a fresh divide behaves normally
    flush();
    seen0 = ready_seen;
    t0 = cyc;
    pulse(DIVU, 32'd100, 32'd7);
    goto_cycle(t0 + 10);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    goto_cycle(t0 + 12);
    check("clear_result_kept", bus.result, 32'd0);
    issue(DIVU, 32'd9, 32'd3, 32'd3, 33);
    wait_done(60);
    check("clear_ready_count", ready_seen - seen0, 32'd1);

    // synchronous reset mid-divide aborts like power-up
    flush();
    seen0 = ready_seen;
    t0 = cyc;
    pulse(DIVU, 32'd100, 32'd7);
    goto_cycle(t0 + 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset_ready", {31'b0, bus.ready}, 32'd0);
    check("midreset_result", bus.result, 32'd0);
    repeat (40) tick();
    check("midreset_no_ready", ready_seen - seen0, 32'd0);

    // enable pulses while busy are ignored
    seen0 = ready_seen;
    t0 = cyc;
    issue(DIVU, 32'd100, 32'd7, 32'd14, 33);
    goto_cycle(t0 + 3);
    pulse(DIVU, 32'd50, 32'd5);
    goto_cycle(t0 + 10);
    pulse(REMU, 32'd77, 32'd10);
    wait_done(60);
    repeat (5) tick();
    check("busy_enable_ready_count", ready_seen - seen0, 32'd1);

    // repeat of an identical request: cached when enabled, full length otherwise
    flush();
    run(DIVU, 32'd100, 32'd7, 32'd14, 33);
`ifdef DIVIDER_CACHE_EN
    run(DIVU, 32'd100, 32'd7, 32'd14, 1);
`else
    run(DIVU, 32'd100, 32'd7, 32'd14, 33);
`endif
    flush();
    run(DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
